// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams host configuration words LSB first onto the
// shared fabric shift line, enabling one column chain at a time. After the
// selected columns are loaded it pulses cset to latch the configuration.
// Every output is a flop; the flop inputs are derived from the next state.
module fpga_config_loader #(
    parameter int MX       = 4,
    parameter int COL_BITS = 1024,
    parameter int WORD_W   = 32,
    parameter int CNT_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MX-1:0]     col_mask,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic [MX-1:0]     col_cen,
    output logic              shift_out,
    output logic              cset,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int               BC_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] COL_END  = CNT_W'(COL_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(COL_BITS - 1);
    localparam logic [BC_W-1:0]  BUF_FULL = BC_W'(WORD_W);
    localparam logic [BC_W-1:0]  BUF_ONE  = BC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_LOAD,
        S_SET,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [MX-1:0]     pend_q, pend_d;        // columns still to load
    logic [MX-1:0]     cur_q, cur_d;          // one-hot column being loaded
    logic              loaded_q, loaded_d;    // any column loaded this run
    logic [CNT_W-1:0]  cnt_q, cnt_d;          // bits shifted into current column
    logic [BC_W-1:0]   bcnt_q, bcnt_d;        // bits left in the word buffer
    logic [WORD_W-1:0] buf_q, buf_d;          // buf_q[0] is the bit on shift_out

    logic              word_ready_q, word_ready_d;
    logic [MX-1:0]     col_cen_q, col_cen_d;
    logic              shift_out_q, shift_out_d;
    logic              cset_q, cset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              accept;
    logic              shift_en;
    logic [MX-1:0]     lowest;
    logic [CNT_W-1:0]  cnt_inc;

    assign accept  = word_valid && word_ready_q;
    assign lowest  = pend_q & (~pend_q + MX'(1));
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and next-output computation for the whole loader.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cur_d     = cur_q;
        loaded_d  = loaded_q;
        cnt_d     = cnt_q;
        bcnt_d    = bcnt_q;
        buf_d     = buf_q;
        aborted_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_d   = col_mask;
                    loaded_d = 1'b0;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                cnt_d  = '0;
                bcnt_d = '0;
                if (pend_q != '0) begin
                    cur_d    = lowest;
                    pend_d   = pend_q & ~lowest;
                    loaded_d = 1'b1;
                    state_d  = S_LOAD;
                end else if (loaded_q) begin
                    state_d = S_SET;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_LOAD: begin
                if (bcnt_q != '0) begin
                    // The bit on shift_out this cycle is consumed.
                    buf_d  = buf_q >> 1;
                    bcnt_d = bcnt_q - BC_W'(1);
                    cnt_d  = cnt_inc;
                    if (cnt_inc == COL_END) begin
                        // Column complete: leftover word bits are dropped so
                        // the next column begins on a fresh word.
                        bcnt_d  = '0;
                        state_d = S_NEXT;
                    end else if (accept) begin
                        buf_d  = word_data;
                        bcnt_d = BUF_FULL;
                    end
                end else if (accept) begin
                    buf_d  = word_data;
                    bcnt_d = BUF_FULL;
                end
            end
            S_SET: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && abort) begin
            state_d   = S_IDLE;
            pend_d    = '0;
            bcnt_d    = '0;
            aborted_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        shift_en     = (state_d == S_LOAD) && (bcnt_d != '0);
        col_cen_d    = shift_en ? cur_d : '0;
        shift_out_d  = shift_en ? buf_d[0] : shift_out_q;
        // Ready when the buffer will be empty, or its last bit leaves that
        // cycle without being the final bit of the column.
        word_ready_d = (state_d == S_LOAD) &&
                       ((bcnt_d == '0) || (bcnt_d == BUF_ONE && cnt_d != LAST_BIT));
        cset_d       = (state_d == S_SET);
        done_d       = (state_d == S_FIN);
        busy_d       = (state_d != S_IDLE);
    end

    // FSM, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pend_q       <= '0;
            cur_q        <= '0;
            loaded_q     <= 1'b0;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            word_ready_q <= 1'b0;
            col_cen_q    <= '0;
            shift_out_q  <= 1'b0;
            cset_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cur_q        <= cur_d;
            loaded_q     <= loaded_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            word_ready_q <= word_ready_d;
            col_cen_q    <= col_cen_d;
            shift_out_q  <= shift_out_d;
            cset_q       <= cset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Word buffer data; its contents are meaningful only while bcnt_q is non-zero.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign word_ready = word_ready_q;
    assign col_cen    = col_cen_q;
    assign shift_out  = shift_out_q;
    assign cset       = cset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader with MX=4, COL_BITS=10, WORD_W=4.
module tb_fpga_config_loader;

    localparam int MX       = 4;
    localparam int COL_BITS = 10;
    localparam int WORD_W   = 4;
    localparam int CNT_W    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [MX-1:0]     col_mask;
    logic              abort;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic [MX-1:0]     col_cen;
    logic              shift_out;
    logic              cset;
    logic              busy;
    logic              done;
    logic              aborted;

    always #5 clk = ~clk;

    fpga_config_loader #(
        .MX(MX), .COL_BITS(COL_BITS), .WORD_W(WORD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .col_mask(col_mask),
        .abort(abort), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .col_cen(col_cen), .shift_out(shift_out),
        .cset(cset), .busy(busy), .done(done), .aborted(aborted)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [WORD_W-1:0] words[$];
    int  widx;
    bit  host_en;
    int  stall_left;
    bit  stall_req;

    int  hi[MX];
    int  runs[MX];
    int  gap[MX];
    int  last_hi, cur_col, ord, pos;
    int  bit_err, multi_err;
    int  cset_n, done_n, abrt_n, rdy_n;
    int  cset_cyc, done_cyc, first_cen, last_cen, t_start;
    logic [15:0] seq_code;
    logic busy_at1, rdy_at2;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < MX; i++) begin
            hi[i] = 0; runs[i] = 0; gap[i] = 0;
        end
        last_hi = -10; cur_col = -1; ord = -1; pos = 0;
        bit_err = 0; multi_err = 0;
        cset_n = 0; done_n = 0; abrt_n = 0; rdy_n = 0;
        cset_cyc = -1; done_cyc = -1; first_cen = -1; last_cen = -1;
        seq_code = '0; busy_at1 = 1'b0; rdy_at2 = 1'b0;
    endtask

    // Observe outputs of the current cycle and score them against the word stream.
    task automatic sample();
        int c;
        int wi;
        logic [WORD_W-1:0] w;
        if (col_cen != '0) begin
            if ($countones(col_cen) != 1) multi_err++;
            c = 0;
            for (int i = MX - 1; i >= 0; i--) if (col_cen[i]) c = i;
            if (first_cen < 0) first_cen = cyc;
            if (c != cur_col) begin
                ord++; cur_col = c; pos = 0; runs[c]++;
                seq_code = {seq_code[11:0], 4'(c + 1)};
            end else if (last_hi != cyc - 1) begin
                runs[c]++;
                gap[c] = cyc - last_hi - 1;
            end
            wi = ord * 3 + pos / WORD_W;
            if (wi < words.size()) begin
                w = words[wi];
                if (shift_out !== w[pos % WORD_W]) bit_err++;
            end else begin
                bit_err++;
            end
            pos++; hi[c]++; last_hi = cyc; last_cen = cyc;
            if (stall_req && c == 1 && hi[1] == 3) begin
                stall_left = 3;
                stall_req  = 1'b0;
            end
        end
        if (cset)       begin cset_n++; cset_cyc = cyc; end
        if (done)       begin done_n++; done_cyc = cyc; end
        if (aborted)    abrt_n++;
        if (word_ready) rdy_n++;
        if (cyc == t_start + 1) busy_at1 = busy;
        if (cyc == t_start + 2) rdy_at2 = word_ready;
    endtask

    // One clock: sample at negedge, then drive the next cycle's inputs #1 after posedge.
    task automatic step();
        logic acc;
        @(negedge clk);
        sample();
        acc = word_valid && word_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) widx++;
        start = 1'b0;
        abort = 1'b0;
        if (stall_left > 0) begin
            word_valid = 1'b0;
            stall_left--;
        end else begin
            word_valid = host_en && (widx < words.size());
        end
        word_data = (widx < words.size()) ? words[widx] : '0;
    endtask

    task automatic begin_load(input logic [MX-1:0] mask);
        clear_stats();
        widx       = 0;
        host_en    = 1'b1;
        col_mask   = mask;
        start      = 1'b1;
        t_start    = cyc;
        word_valid = 1'b0;
        word_data  = words[0];
        step();
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (done_n == 0 && abrt_n == 0 && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_completes"}, done_n, 1);
        host_en = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; col_mask = '0;
        word_valid = 1'b0; word_data = '0; host_en = 1'b0;
        stall_left = 0; stall_req = 1'b0; widx = 0; t_start = -10;
        words = '{4'hA, 4'h5, 4'hF, 4'h3, 4'hC, 4'h6,
                  4'h9, 4'h1, 4'hE, 4'h7, 4'hB, 4'hD};
        clear_stats();

        repeat (3) step();
        check_eq("reset_outputs",
                 int'({col_cen, shift_out, cset, busy, done, aborted, word_ready}), 0);
        rst_n = 1'b1;
        step();

        // Full load, continuous host.
        begin_load(4'b1111);
        wait_end("full", 200);
        check_eq("full_busy_t1", int'(busy_at1), 1);
        check_eq("full_ready_t2", int'(rdy_at2), 1);
        check_eq("full_first_cen_latency", first_cen - t_start, 3);
        for (int i = 0; i < MX; i++) begin
            check_eq($sformatf("full_hi_col%0d", i), hi[i], COL_BITS);
            check_eq($sformatf("full_runs_col%0d", i), runs[i], 1);
        end
        check_eq("full_order", int'(seq_code), 'h1234);
        check_eq("full_bits", bit_err, 0);
        check_eq("full_onehot", multi_err, 0);
        check_eq("full_words", widx, 12);
        check_eq("full_cset_count", cset_n, 1);
        check_eq("full_cset_delay", cset_cyc - last_cen, 2);
        check_eq("full_done_after_cset", done_cyc - cset_cyc, 1);

        // Host stall of 3 cycles in column 1.
        stall_req = 1'b1;
        begin_load(4'b1111);
        wait_end("stall", 250);
        check_eq("stall_hi_col1", hi[1], COL_BITS);
        check_eq("stall_runs_col1", runs[1], 2);
        check_eq("stall_gap_col1", gap[1], 3);
        check_eq("stall_bits", bit_err, 0);
        check_eq("stall_words", widx, 12);
        check_eq("stall_cset_count", cset_n, 1);

        // Empty mask.
        begin_load(4'b0000);
        wait_end("empty", 20);
        check_eq("empty_done_latency", done_cyc - t_start, 2);
        check_eq("empty_cen_total", hi[0] + hi[1] + hi[2] + hi[3], 0);
        check_eq("empty_cset_count", cset_n, 0);
        check_eq("empty_ready_count", rdy_n, 0);

        // Abort during column 2.
        begin_load(4'b1111);
        n = 0;
        while (hi[2] < 4 && n < 200) begin
            step();
            n++;
        end
        check_eq("abort_reached_col2", int'(hi[2] >= 4), 1);
        abort = 1'b1;
        step();
        check_eq("abort_col_cen", int'(col_cen), 0);
        check_eq("abort_pulse", int'(aborted), 1);
        check_eq("abort_busy", int'(busy), 0);
        host_en = 1'b0;
        repeat (20) step();
        check_eq("abort_cset_count", cset_n, 0);
        check_eq("abort_done_count", done_n, 0);
        check_eq("abort_pulse_count", abrt_n, 1);

        // Sparse mask after the abort.
        begin_load(4'b0101);
        wait_end("sparse", 200);
        check_eq("sparse_hi_col0", hi[0], COL_BITS);
        check_eq("sparse_hi_col2", hi[2], COL_BITS);
        check_eq("sparse_hi_unused", hi[1] + hi[3], 0);
        check_eq("sparse_order", int'(seq_code), 'h13);
        check_eq("sparse_bits", bit_err, 0);
        check_eq("sparse_words", widx, 6);
        check_eq("sparse_cset_count", cset_n, 1);
        check_eq("sparse_done_after_cset", done_cyc - cset_cyc, 1);

        // Reset for one cycle in the middle of column 1, with start asserted.
        begin_load(4'b1111);
        n = 0;
        while (hi[1] < 3 && n < 200) begin
            step();
            n++;
        end
        check_eq("reset_reached_col1", int'(hi[1] >= 3), 1);
        rst_n = 1'b0;
        start = 1'b1;
        step();
        check_eq("midreset_outputs",
                 int'({col_cen, shift_out, cset, busy, done, aborted, word_ready}), 0);
        rst_n   = 1'b1;
        host_en = 1'b0;
        step();
        check_eq("midreset_start_ignored", int'(busy), 0);

        // Recovery with a single column.
        begin_load(4'b1000);
        wait_end("recover", 100);
        check_eq("recover_hi_col3", hi[3], COL_BITS);
        check_eq("recover_bits", bit_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
